// File: rtl/adc_sequencer.sv
// adc_sequencer: drives the hard ADC through an ascending channel scan
// (select, settle, convert, capture) and emits each result as a one-cycle
// strobe to the storage block. Configured through a small Wishbone slave.
// Optional build macro ADC_SEQ_AVG_EN: four conversions per channel, averaged.
module adc_sequencer #(
    parameter int unsigned MAX_CHANNEL     = 31,
    parameter int unsigned DEFAULT_LAST_CH = 31,
    parameter int unsigned DEFAULT_SETTLE  = 16,
    parameter int unsigned CONV_TIMEOUT    = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [15:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic [4:0]  adc_chnum_o,
    output logic        adc_start_o,
    input  logic        adc_busy_i,
    input  logic        adc_datavalid_i,
    input  logic [11:0] adc_data_i,
    output logic        adc_strb,
    output logic [4:0]  adc_channel,
    output logic [11:0] adc_result
);

    localparam int unsigned CH_W   = 5;
    localparam int unsigned SET_W  = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned WAIT_W = (CONV_TIMEOUT < 2) ? 1 : $clog2(CONV_TIMEOUT + 1);

    // LAST_CH reset value obeys the same clamping rules as a register write
    localparam logic [CH_W-1:0] LAST_CH_RST =
        (DEFAULT_LAST_CH > MAX_CHANNEL) ? CH_W'(MAX_CHANNEL) :
        (DEFAULT_LAST_CH == 0)          ? CH_W'(1)           : CH_W'(DEFAULT_LAST_CH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_START,
        S_WAIT,
        S_EMIT,
        S_NEXT
    } state_t;

    state_t              state;
    logic [CH_W-1:0]     chan;
    logic [SET_W-1:0]    settle_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                enable;
    logic                oneshot;
    logic [CH_W-1:0]     last_ch;
    logic [SET_W-1:0]    settle;
    logic                timeout_err;
    logic [CNT_W-1:0]    timeout_cnt;
    logic                wb_wr;
    logic                timeout_hit;
    logic                busy;
    logic                unused_bits;

`ifdef ADC_SEQ_AVG_EN
    logic [1:0]          conv_idx;
    logic [13:0]         sum;
    logic [13:0]         sum_next;

    assign sum_next = sum + {2'b00, adc_data_i};
`endif

    assign wb_wr       = wb_stb_i & wb_cyc_i & wb_we_i & ~wb_ack_o;
    assign busy        = (state != S_IDLE);
    assign timeout_hit = (state == S_WAIT) && !adc_datavalid_i && (wait_cnt == WAIT_W'(CONV_TIMEOUT));
    assign unused_bits = ^{wb_adr_i[15:2], wb_dat_i[15:8]};

    // LAST_CH write value: 0 forces 1 so a wrap always happens; cap at MAX_CHANNEL
    function automatic logic [CH_W-1:0] clamp_last(input logic [CH_W-1:0] v);
        if (v == '0) begin
            return CH_W'(1);
        end else if (32'(v) > MAX_CHANNEL) begin
            return CH_W'(MAX_CHANNEL);
        end else begin
            return v;
        end
    endfunction

    // Single-cycle Wishbone acknowledge, never back-to-back
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wb_ack_o <= 1'b0;
        end else begin
            wb_ack_o <= wb_stb_i & wb_cyc_i & ~wb_ack_o;
        end
    end

    // Combinational register read, driven only while the slave is addressed
    always_comb begin
        wb_dat_o = '0;
        if (wb_stb_i && wb_cyc_i) begin
            case (wb_adr_i[1:0])
                2'd0:    wb_dat_o = {13'd0, 1'b0, oneshot, enable};
                2'd1:    wb_dat_o = {11'd0, last_ch};
                2'd2:    wb_dat_o = {8'd0, settle};
                default: wb_dat_o = {busy, timeout_err, 1'b0, chan, timeout_cnt};
            endcase
        end
    end

    // Scan FSM, ADC handshake, result capture and configuration registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= S_IDLE;
            chan        <= '0;
            settle_cnt  <= '0;
            wait_cnt    <= '0;
            enable      <= 1'b0;
            oneshot     <= 1'b0;
            last_ch     <= LAST_CH_RST;
            settle      <= SET_W'(DEFAULT_SETTLE);
            timeout_err <= 1'b0;
            timeout_cnt <= '0;
            adc_chnum_o <= '0;
            adc_start_o <= 1'b0;
            adc_strb    <= 1'b0;
            adc_channel <= '0;
            adc_result  <= '0;
`ifdef ADC_SEQ_AVG_EN
            conv_idx    <= '0;
            sum         <= '0;
`endif
        end else begin
            adc_start_o <= 1'b0;
            adc_strb    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (enable) begin
                        chan  <= '0;
                        state <= S_SELECT;
                    end
                end

                S_SELECT: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else begin
                        adc_chnum_o <= chan;
                        settle_cnt  <= settle;
                        state       <= S_SETTLE;
`ifdef ADC_SEQ_AVG_EN
                        conv_idx    <= '0;
                        sum         <= '0;
`endif
                    end
                end

                // SETTLE=0 and SETTLE=1 both spend a single clock here
                S_SETTLE: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (settle_cnt <= SET_W'(1)) begin
                        state <= S_START;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end

                S_START: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (!adc_busy_i) begin
                        adc_start_o <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= S_WAIT;
                    end
                end

                // Conversion always completes (or times out) even if disabled
                S_WAIT: begin
                    if (adc_datavalid_i) begin
`ifdef ADC_SEQ_AVG_EN
                        if (conv_idx == 2'd3) begin
                            adc_result  <= sum_next[13:2];
                            adc_channel <= chan;
                            adc_strb    <= 1'b1;
                            state       <= S_EMIT;
                        end else begin
                            sum      <= sum_next;
                            conv_idx <= conv_idx + 2'd1;
                            state    <= S_START;
                        end
`else
                        adc_result  <= adc_data_i;
                        adc_channel <= chan;
                        adc_strb    <= 1'b1;
                        state       <= S_EMIT;
`endif
                    end else if (timeout_hit) begin
                        timeout_err <= 1'b1;
                        if (timeout_cnt != '1) begin
                            timeout_cnt <= timeout_cnt + CNT_W'(1);
                        end
                        state <= S_NEXT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                S_EMIT: begin
                    state <= enable ? S_NEXT : S_IDLE;
                end

                // Wrap on >= so a LAST_CH lowered mid-scan takes effect here
                S_NEXT: begin
                    if (chan >= last_ch) begin
                        chan <= '0;
                        if (oneshot) begin
                            enable  <= 1'b0;
                            oneshot <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            state <= enable ? S_SELECT : S_IDLE;
                        end
                    end else begin
                        chan  <= chan + CH_W'(1);
                        state <= enable ? S_SELECT : S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase

            // Register writes land on the ack edge and override FSM updates
            if (wb_wr) begin
                case (wb_adr_i[1:0])
                    2'd0: begin
                        enable  <= wb_dat_i[0];
                        oneshot <= wb_dat_i[1];
                        if (wb_dat_i[2] && !timeout_hit) begin
                            timeout_err <= 1'b0;
                        end
                    end
                    2'd1:    last_ch <= clamp_last(wb_dat_i[4:0]);
                    2'd2:    settle  <= wb_dat_i[7:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_sequencer.sv
// Testbench for adc_sequencer: behavioural hard-ADC model plus scan-order
// reference, randomized conversion latency and data.
`timescale 1ns/1ps
module tb_adc_sequencer;

    localparam int MAXCH = 7;
`ifdef ADC_SEQ_AVG_EN
    localparam int NCONV = 4;
`else
    localparam int NCONV = 1;
`endif

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni;
    logic        wb_stb_i, wb_cyc_i, wb_we_i;
    logic [15:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic        wb_ack_o;
    logic [4:0]  adc_chnum_o;
    logic        adc_start_o;
    logic        adc_busy_i;
    logic        adc_datavalid_i;
    logic [11:0] adc_data_i;
    logic        adc_strb;
    logic [4:0]  adc_channel;
    logic [11:0] adc_result;

    int vectors     = 0;
    int miscompares = 0;

    // ADC model controls and bookkeeping
    int mute_ch     = -1;
    int data_mode   = 0;
    int fixed_delay = 0;
    int start_cnt   = 0;
    int acc  [32];
    int nacc [32];
    int conv_left;
    int conv_ch;

    logic [16:0] got_q[$];
    logic [16:0] exp_q[$];

    adc_sequencer #(
        .MAX_CHANNEL    (MAXCH),
        .DEFAULT_LAST_CH(MAXCH),
        .DEFAULT_SETTLE (16),
        .CONV_TIMEOUT   (255)
    ) dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_ni      (wb_rst_ni),
        .wb_stb_i       (wb_stb_i),
        .wb_cyc_i       (wb_cyc_i),
        .wb_we_i        (wb_we_i),
        .wb_adr_i       (wb_adr_i),
        .wb_dat_i       (wb_dat_i),
        .wb_dat_o       (wb_dat_o),
        .wb_ack_o       (wb_ack_o),
        .adc_chnum_o    (adc_chnum_o),
        .adc_start_o    (adc_start_o),
        .adc_busy_i     (adc_busy_i),
        .adc_datavalid_i(adc_datavalid_i),
        .adc_data_i     (adc_data_i),
        .adc_strb       (adc_strb),
        .adc_channel    (adc_channel),
        .adc_result     (adc_result)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Hard-ADC model: starts on adc_start_o, answers after a latency, and
    // records the result the sequencer should report for each channel
    initial begin
        logic [11:0] v;
        adc_busy_i      = 1'b0;
        adc_datavalid_i = 1'b0;
        adc_data_i      = '0;
        conv_left       = 0;
        conv_ch         = 0;
        forever begin
            @(posedge wb_clk_i); #1;
            adc_datavalid_i = 1'b0;
            if (adc_busy_i) begin
                conv_left--;
                if (conv_left <= 0) begin
                    adc_busy_i = 1'b0;
                    if (conv_ch != mute_ch) begin
                        case (data_mode)
                            0:       v = 12'(32'h100 + conv_ch);
                            1:       v = 12'($urandom);
                            default: case (nacc[conv_ch])
                                         0:       v = 12'd10;
                                         1:       v = 12'd11;
                                         2:       v = 12'd12;
                                         default: v = 12'd14;
                                     endcase
                        endcase
                        adc_data_i      = v;
                        adc_datavalid_i = 1'b1;
                        acc[conv_ch]   += int'(v);
                        nacc[conv_ch]++;
                        if (nacc[conv_ch] == NCONV) begin
                            exp_q.push_back({5'(conv_ch), 12'(acc[conv_ch] / NCONV)});
                            acc[conv_ch]  = 0;
                            nacc[conv_ch] = 0;
                        end
                    end
                end
            end else if (adc_start_o) begin
                start_cnt++;
                conv_ch    = int'(adc_chnum_o);
                adc_busy_i = 1'b1;
                conv_left  = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(12, 1));
            end
        end
    end

    // Strobe monitor
    initial begin
        forever begin
            @(posedge wb_clk_i); #1;
            if (adc_strb) got_q.push_back({adc_channel, adc_result});
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    // Reference scan order: ascending from 0, wrapping after last, muted channel absent
    function automatic int ref_ch(input int idx, input int last, input int mute);
        int ch = -1;
        int k  = 0;
        for (int n = 0; n < 1024; n++) begin
            ch = (ch >= last) ? 0 : ch + 1;
            if (ch != mute) begin
                if (k == idx) return ch;
                k++;
            end
        end
        return -1;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 32; i++) begin
            acc[i]  = 0;
            nacc[i] = 0;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [15:0] d);
        int n = 0;
        @(posedge wb_clk_i); #1;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = {14'd0, a}; wb_dat_i = d;
        do begin
            @(posedge wb_clk_i); #1;
            n++;
        end while (!wb_ack_o && n < 10);
        if (!wb_ack_o) begin
            vectors++; miscompares++;
            $display("FAIL wb_write_ack: no ack within 10 clocks, addr %0d", a);
        end
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [15:0] d);
        int n = 0;
        @(posedge wb_clk_i); #1;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = {14'd0, a};
        do begin
            @(posedge wb_clk_i); #1;
            n++;
        end while (!wb_ack_o && n < 10);
        if (!wb_ack_o) begin
            vectors++; miscompares++;
            $display("FAIL wb_read_ack: no ack within 10 clocks, addr %0d", a);
        end
        d = wb_dat_o;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int c = 0;
        while (got_q.size() < n && c < budget) begin
            @(posedge wb_clk_i); #1;
            c++;
        end
        if (got_q.size() < n) begin
            vectors++; miscompares++;
            $display("FAIL wait_strobes: got %0d strobes, required %0d within %0d clocks", got_q.size(), n, budget);
        end
    endtask

    task automatic wait_idle();
        logic [15:0] rd;
        int c = 0;
        do begin
            wb_read(2'd3, rd);
            c++;
        end while (rd[15] && c < 200);
        if (rd[15]) begin
            vectors++; miscompares++;
            $display("FAIL wait_idle: sequencer still busy after %0d status reads", c);
        end
    endtask

    // Compare collected strobes to the reference scan order and model results
    task automatic check_strobes(input string tag, input int n, input int last, input int mute, input bit fixed_data);
        logic [16:0] g, e;
        for (int i = 0; i < n; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 17'h1FFFF;
            e = (i < exp_q.size()) ? exp_q[i] : 17'h1FFFF;
            vectors++;
            if (g[16:12] !== 5'(ref_ch(i, last, mute))) begin
                miscompares++;
                $display("FAIL %s_ch[%0d]: got %0d required %0d", tag, i, g[16:12], ref_ch(i, last, mute));
            end
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL %s_res[%0d]: got ch%0d/%h required ch%0d/%h", tag, i, g[16:12], g[11:0], e[16:12], e[11:0]);
            end
            if (fixed_data) begin
                vectors++;
                if (g[11:0] !== 12'(32'h100 + ref_ch(i, last, mute))) begin
                    miscompares++;
                    $display("FAIL %s_val[%0d]: got %h required %h", tag, i, g[11:0], 12'(32'h100 + ref_ch(i, last, mute)));
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        wb_rst_ni = 1'b0;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0;
        repeat (3) @(posedge wb_clk_i);
        #1 wb_rst_ni = 1'b1;
        repeat (2) @(posedge wb_clk_i);
        #1;
        vectors++;
        if ({adc_strb, adc_start_o, adc_chnum_o, adc_channel, adc_result, wb_ack_o, wb_dat_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: strb %b start %b chnum %0d ch %0d res %h ack %b dat %h, required all 0",
                     adc_strb, adc_start_o, adc_chnum_o, adc_channel, adc_result, wb_ack_o, wb_dat_o);
        end
        wb_read(2'd0, rd);
        vectors++;
        if (rd !== 16'd0) begin miscompares++; $display("FAIL reset_ctrl: got %h required 0000", rd); end
        wb_read(2'd1, rd);
        vectors++;
        if (rd !== 16'(MAXCH)) begin miscompares++; $display("FAIL reset_last_ch: got %h required %h", rd, 16'(MAXCH)); end
        wb_read(2'd2, rd);
        vectors++;
        if (rd !== 16'd16) begin miscompares++; $display("FAIL reset_settle: got %h required 0010", rd); end
        wb_read(2'd3, rd);
        vectors++;
        if (rd !== 16'd0) begin miscompares++; $display("FAIL reset_status: got %h required 0000", rd); end
    endtask

    task automatic test_scan();
        reset_model();
        data_mode = 0; mute_ch = -1; fixed_delay = 0;
        wb_write(2'd1, 16'd3);
        wb_write(2'd2, 16'd2);
        wb_write(2'd0, 16'd1);
        wait_strobes(8, 3000);
        wb_write(2'd0, 16'd0);
        wait_idle();
        check_strobes("scan", 8, 3, -1, 1'b1);
    endtask

    task automatic test_oneshot();
        logic [15:0] rd;
        int s0;
        reset_model();
        data_mode = 1;
        wb_write(2'd2, 16'($urandom_range(3, 0)));
        wb_write(2'd1, 16'd2);
        s0 = start_cnt;
        wb_write(2'd0, 16'd3);
        wait_strobes(3, 3000);
        wait_idle();
        repeat (20) @(posedge wb_clk_i);
        #1;
        vectors++;
        if (got_q.size() != 3) begin miscompares++; $display("FAIL oneshot_count: got %0d strobes required 3", got_q.size()); end
        check_strobes("oneshot", 3, 2, -1, 1'b0);
        vectors++;
        if (start_cnt - s0 != 3 * NCONV) begin
            miscompares++;
            $display("FAIL oneshot_starts: got %0d start pulses required %0d", start_cnt - s0, 3 * NCONV);
        end
        wb_read(2'd0, rd);
        vectors++;
        if (rd !== 16'd0) begin miscompares++; $display("FAIL oneshot_ctrl: got %h required 0000", rd); end
        wb_read(2'd3, rd);
        vectors++;
        if (rd[15] !== 1'b0) begin miscompares++; $display("FAIL oneshot_busy: got %b required 0", rd[15]); end
    endtask

    task automatic test_last_ch_clamp();
        logic [15:0] rd;
        logic [15:0] v;
        wb_write(2'd1, 16'd31);
        wb_read(2'd1, rd);
        vectors++;
        if (rd !== 16'(MAXCH)) begin miscompares++; $display("FAIL clamp_31: got %0d required %0d", rd, MAXCH); end
        v = 16'($urandom_range(31, MAXCH + 1));
        wb_write(2'd1, v);
        wb_read(2'd1, rd);
        vectors++;
        if (rd !== 16'(MAXCH)) begin miscompares++; $display("FAIL clamp_high(%0d): got %0d required %0d", v, rd, MAXCH); end
        v = 16'($urandom_range(MAXCH, 1));
        wb_write(2'd1, v);
        wb_read(2'd1, rd);
        vectors++;
        if (rd !== v) begin miscompares++; $display("FAIL clamp_pass: got %0d required %0d", rd, v); end
        wb_write(2'd1, 16'd0);
        wb_read(2'd1, rd);
        vectors++;
        if (rd !== 16'd1) begin miscompares++; $display("FAIL clamp_zero: got %0d required 1", rd); end
        reset_model();
        data_mode = 1;
        wb_write(2'd2, 16'd1);
        wb_write(2'd0, 16'd1);
        wait_strobes(4, 3000);
        wb_write(2'd0, 16'd0);
        wait_idle();
        check_strobes("wrap01", 4, 1, -1, 1'b0);
    endtask

    task automatic test_timeout();
        logic [15:0] rd;
        int base;
        reset_model();
        data_mode = 1; mute_ch = 1;
        wb_write(2'd2, 16'd2);
        wb_write(2'd1, 16'd2);
        wb_write(2'd0, 16'd4);
        wb_read(2'd3, rd);
        base = int'(rd[7:0]);
        vectors++;
        if (rd[14] !== 1'b0) begin miscompares++; $display("FAIL timeout_pre_err: got %b required 0", rd[14]); end
        for (int scan = 1; scan <= 2; scan++) begin
            got_q.delete();
            exp_q.delete();
            wb_write(2'd0, 16'd3);
            wait_strobes(2, 3000);
            wait_idle();
            check_strobes("timeout", 2, 2, 1, 1'b0);
            wb_read(2'd3, rd);
            vectors++;
            if (rd[14] !== 1'b1) begin miscompares++; $display("FAIL timeout_err[%0d]: got %b required 1", scan, rd[14]); end
            vectors++;
            if (int'(rd[7:0]) != base + scan) begin
                miscompares++;
                $display("FAIL timeout_cnt[%0d]: got %0d required %0d", scan, rd[7:0], base + scan);
            end
        end
        wb_write(2'd0, 16'd4);
        wb_read(2'd3, rd);
        vectors++;
        if (rd[14] !== 1'b0) begin miscompares++; $display("FAIL clr_err: got %b required 0", rd[14]); end
        vectors++;
        if (int'(rd[7:0]) != base + 2) begin miscompares++; $display("FAIL clr_err_cnt: got %0d required %0d", rd[7:0], base + 2); end
        mute_ch = -1;
    endtask

    task automatic test_reset_abort();
        logic [15:0] rd;
        int c = 0;
        reset_model();
        data_mode = 0; fixed_delay = 20;
        wb_write(2'd1, 16'd3);
        wb_write(2'd2, 16'd2);
        wb_write(2'd0, 16'd1);
        while (!adc_start_o && c < 200) begin
            @(posedge wb_clk_i); #1;
            c++;
        end
        vectors++;
        if (!adc_start_o) begin miscompares++; $display("FAIL abort_start: no adc_start_o within 200 clocks"); end
        repeat (3) @(posedge wb_clk_i);
        #1 wb_rst_ni = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1 wb_rst_ni = 1'b1;
        repeat (40) @(posedge wb_clk_i);
        #1;
        vectors++;
        if (got_q.size() != 0) begin miscompares++; $display("FAIL abort_strobe: got %0d strobes required 0", got_q.size()); end
        vectors++;
        if ({adc_strb, adc_start_o, adc_chnum_o, adc_channel, adc_result} !== '0) begin
            miscompares++;
            $display("FAIL abort_outputs: strb %b start %b chnum %0d ch %0d res %h, required all 0",
                     adc_strb, adc_start_o, adc_chnum_o, adc_channel, adc_result);
        end
        wb_read(2'd3, rd);
        vectors++;
        if (rd !== 16'd0) begin miscompares++; $display("FAIL abort_status: got %h required 0000", rd); end
        fixed_delay = 0;
    endtask

    task automatic test_disable_in_settle();
        logic [15:0] rd;
        int s0;
        reset_model();
        data_mode = 1;
        wb_write(2'd2, 16'd40);
        wb_write(2'd1, 16'd3);
        wb_write(2'd0, 16'd1);
        wait_strobes(1, 3000);
        repeat (5) @(posedge wb_clk_i);
        wb_write(2'd0, 16'd0);
        s0 = start_cnt;
        repeat (80) @(posedge wb_clk_i);
        #1;
        vectors++;
        if (start_cnt != s0) begin miscompares++; $display("FAIL disable_starts: got %0d extra start pulses required 0", start_cnt - s0); end
        vectors++;
        if (got_q.size() != 1) begin miscompares++; $display("FAIL disable_strobes: got %0d required 1", got_q.size()); end
        wb_read(2'd3, rd);
        vectors++;
        if (rd[15] !== 1'b0) begin miscompares++; $display("FAIL disable_busy: got %b required 0", rd[15]); end
    endtask

`ifdef ADC_SEQ_AVG_EN
    task automatic test_avg();
        int s0;
        reset_model();
        data_mode = 2;
        wb_write(2'd2, 16'd1);
        wb_write(2'd1, 16'd1);
        s0 = start_cnt;
        wb_write(2'd0, 16'd3);
        wait_strobes(2, 3000);
        wait_idle();
        check_strobes("avg", 2, 1, -1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (i >= got_q.size() || got_q[i][11:0] !== 12'd11) begin
                miscompares++;
                $display("FAIL avg_value[%0d]: got %h required 00b", i, (i < got_q.size()) ? got_q[i][11:0] : 12'hFFF);
            end
        end
        vectors++;
        if (start_cnt - s0 != 8) begin miscompares++; $display("FAIL avg_starts: got %0d required 8", start_cnt - s0); end
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_oneshot();
        test_last_ch_clamp();
        test_timeout();
        test_disable_in_settle();
        test_reset_abort();
`ifdef ADC_SEQ_AVG_EN
        test_avg();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_sequencer.md
Name: adc_sequencer

Overview:
- Front end of the monitor sample path. Drives the hard ADC through an ascending channel scan: channel select, settle, convert, capture.
- Emits each result as a one-cycle strobe with channel and 12-bit value. The ring-buffer storage block consumes this stream.
- The storage block detects the end of a scan when a channel number is lower than the previous one, so scan order is strictly ascending, wrapping to 0.
- Configured through a small Wishbone slave.

Parameters:
- MAX_CHANNEL, 31: highest channel the hardware supports; LAST_CH is clamped to this value.
- DEFAULT_LAST_CH, 31: reset value of LAST_CH.
- DEFAULT_SETTLE, 16: reset value of SETTLE, in clocks.
- CONV_TIMEOUT, 255: clocks allowed in WAIT before the conversion is abandoned.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_ni  in  1  reset, asynchronous assert, active-low
- wb_stb_i, wb_cyc_i, wb_we_i  in  1 each  Wishbone strobe, cycle, write-enable
- wb_adr_i  in  16  Wishbone address; only [1:0] decoded
- wb_dat_i  in  16  write data
- wb_dat_o  out  16  read data
- wb_ack_o  out  1  Wishbone acknowledge
- adc_chnum_o  out  5  hard-ADC channel select
- adc_start_o  out  1  one-cycle conversion start
- adc_busy_i  in  1  hard ADC converting
- adc_datavalid_i  in  1  one-cycle result-valid from hard ADC
- adc_data_i  in  12  hard-ADC result
- adc_strb  out  1  one-cycle result strobe to storage
- adc_channel  out  5  channel of current result
- adc_result  out  12  result value

Behaviour:
- Reset: all outputs 0. FSM in IDLE, channel counter 0, CTRL=0, LAST_CH=DEFAULT_LAST_CH, SETTLE=DEFAULT_SETTLE, TIMEOUT_CNT=0.
- Reset mid-conversion aborts immediately. A late adc_datavalid_i arriving in IDLE is ignored.
- Wishbone:
  - Ack one cycle after stb&cyc&!ack, so single-cycle ack, never back-to-back.
  - Writes take effect on the ack cycle. Reads are combinational on wb_adr_i[1:0].
- Register map (by wb_adr_i[1:0]):
  - 0 CTRL: bit0 ENABLE, bit1 ONESHOT, bit2 CLR_ERR (write-1 pulse, reads 0).
  - 1 LAST_CH [4:0]: writes of 0 clamp to 1, so a wrap always occurs and the storage checkpoint advances; writes above MAX_CHANNEL clamp to MAX_CHANNEL.
  - 2 SETTLE [7:0].
  - 3 STATUS, read-only: [15] busy (FSM != IDLE), [14] TIMEOUT_ERR sticky, [12:8] current channel, [7:0] TIMEOUT_CNT (saturates at 255).
- FSM states: IDLE, SELECT, SETTLE, START, WAIT, EMIT, NEXT.
  - IDLE: when ENABLE=1, go to SELECT with channel=0.
  - SELECT: adc_chnum_o <= channel; load settle counter with SETTLE; go to SETTLE.
  - SETTLE: decrement each clock; at 0 go to START. SETTLE=0 passes straight through (1 clock).
  - START: adc_start_o=1 for exactly one clock, only if adc_busy_i=0; otherwise hold in START. Then go to WAIT and clear the wait counter.
  - WAIT on adc_datavalid_i: capture adc_data_i; go to EMIT.
  - WAIT with wait counter = CONV_TIMEOUT: set TIMEOUT_ERR, increment TIMEOUT_CNT, go to NEXT with no strobe; the channel is skipped.
  - EMIT: adc_strb=1 for one clock; adc_channel/adc_result registered and held stable until the next EMIT.
  - NEXT: if channel==LAST_CH, channel <= 0; if ONESHOT, clear ENABLE and go to IDLE; otherwise go to SELECT. If channel!=LAST_CH, channel <= channel+1 and go to SELECT.
  - Any state other than WAIT with ENABLE=0 goes to IDLE at the next transition point. WAIT finishes its conversion, then EMIT, then goes to IDLE.
- Latency: datavalid to adc_strb is 1 clock. Per channel: SETTLE+4 clocks plus conversion time.
- LAST_CH written mid-scan takes effect at the next NEXT. If the current channel is already above the new LAST_CH, it wraps at that NEXT.
- CLR_ERR and a timeout in the same cycle: the timeout wins and the flag stays set.

Optional Feature:
- Macro ADC_SEQ_AVG_EN.
- Defined:
  - Each channel converts 4 times: START/WAIT repeated 4x with no re-settle.
  - Results accumulate in a 14-bit sum; adc_result = sum[13:2], truncating.
  - A timeout on any of the 4 conversions skips the channel and discards the sum.
- Undefined: single conversion per channel, as specified above.

Test Plan:
- LAST_CH=3, SETTLE=2, ENABLE=1; ADC model returns 12'h100+ch after 10 clocks → adc_strb sequence ch 0,1,2,3,0,… with results 100,101,102,103; exactly one strobe per channel.
- ONESHOT|ENABLE, LAST_CH=2 → exactly 3 strobes (ch 0,1,2); then STATUS[15]=0 and CTRL reads 0.
- Write LAST_CH=0 → reads back 1; scan 0,1,0,1. Write LAST_CH=31 with MAX_CHANNEL=7 → reads back 7.
- Model never asserts datavalid on ch1, LAST_CH=2 → strobes ch0, ch2 only; ch1 abandoned after 255 clocks in WAIT; STATUS[14]=1 and TIMEOUT_CNT=1 per scan; CLR_ERR clears bit 14.
- Assert wb_rst_ni low during WAIT, then feed a late datavalid → no strobe, all outputs 0, IDLE. Clear ENABLE during SETTLE → no further adc_start_o.
- With ADC_SEQ_AVG_EN, conversions 10,11,12,14 → adc_result=11; exactly 4 adc_start_o pulses per channel.
